// File: rtl/music_seq_ctrl_if.sv
// Control, ROM and tone-generator signals of the music playback sequencer.
// The sequencer uses the slave modport; the master side drives controls and ROM data.
interface music_seq_ctrl_if;
    logic       play;
    logic       pause;
    logic       stop;
    logic [1:0] song_sel;
    logic [1:0] tempo;
    logic       loop_en;
    logic [4:0] rom_data;
    logic [8:0] rom_addr;
    logic [4:0] note;
    logic       note_valid;
    logic       playing;
    logic       paused;
    logic       beat;
    logic       done;

    modport slave (
        input  play, pause, stop, song_sel, tempo, loop_en, rom_data,
        output rom_addr, note, note_valid, playing, paused, beat, done
    );

    modport master (
        output play, pause, stop, song_sel, tempo, loop_en, rom_data,
        input  rom_addr, note, note_valid, playing, paused, beat, done
    );
endinterface

// File: rtl/music_seq_ctrl.sv
// Music-ROM playback sequencer: steps the note address at a beat rate set by a cycle
// counter, with play/pause/stop, four song windows, looping and an articulation gap.
module music_seq_ctrl #(
    parameter int unsigned TICK_DIV   = 6250000,
    parameter int unsigned GAP_CYCLES = 625000,
    parameter int unsigned START0     = 0,
    parameter int unsigned END0       = 139,
    parameter int unsigned START1     = 140,
    parameter int unsigned END1       = 279,
    parameter int unsigned START2     = 280,
    parameter int unsigned END2       = 420,
    parameter int unsigned START3     = 421,
    parameter int unsigned END3       = 511
) (
    input logic              in_clk,
    input logic              rst,
    music_seq_ctrl_if.slave  bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StPlay  = 2'd2;
    localparam logic [1:0] StPause = 2'd3;

    localparam logic [31:0] TickDiv = 32'(TICK_DIV);
    localparam logic [31:0] GapCyc  = 32'(GAP_CYCLES);

    logic [1:0]  r_state, w_state_d;
    logic [31:0] r_cnt, w_cnt_d;
    logic [31:0] r_per, w_per_d;
    logic [31:0] r_gap, w_gap_d;
    logic [8:0]  r_addr, w_addr_d;
    logic [1:0]  r_song, w_song_d;
    logic [4:0]  r_note, w_note_d;
    logic        r_nv, w_nv_d;
    logic        r_beat, w_beat_d;
    logic        r_done, w_done_d;
    logic        r_pend, w_pend_d;

    logic [31:0] w_per_tempo;
    logic [31:0] w_gap_tempo;
    logic [31:0] w_gap_start;
    logic [31:0] w_cnt_inc;
    logic [8:0]  w_start;
    logic [8:0]  w_end;
    logic [8:0]  w_sel_start;
    logic        w_last;
    logic        w_at_end;
    logic [4:0]  w_note_now;

    function automatic logic [8:0] song_start(input logic [1:0] s);
        case (s)
            2'd0:    song_start = 9'(START0);
            2'd1:    song_start = 9'(START1);
            2'd2:    song_start = 9'(START2);
            default: song_start = 9'(START3);
        endcase
    endfunction

    function automatic logic [8:0] song_end(input logic [1:0] s);
        case (s)
            2'd0:    song_end = 9'(END0);
            2'd1:    song_end = 9'(END1);
            2'd2:    song_end = 9'(END2);
            default: song_end = 9'(END3);
        endcase
    endfunction

    assign w_per_tempo = TickDiv >> bus.tempo;
    assign w_gap_tempo = GapCyc >> bus.tempo;
    assign w_gap_start = r_per - r_gap;
    assign w_cnt_inc   = r_cnt + 32'd1;
    assign w_start     = song_start(r_song);
    assign w_end       = song_end(r_song);
    assign w_sel_start = song_start(bus.song_sel);
    assign w_last      = (r_cnt == r_per - 32'd1);
    assign w_at_end    = (r_addr == w_end);
    // A pause taken on a beat boundary skips FETCH, so the note loads on the first pause cycle.
    assign w_note_now  = r_pend ? bus.rom_data : r_note;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_per_d   = r_per;
        w_gap_d   = r_gap;
        w_addr_d  = r_addr;
        w_song_d  = r_song;
        w_note_d  = r_note;
        w_nv_d    = r_nv;
        w_beat_d  = 1'b0;
        w_done_d  = 1'b0;
        w_pend_d  = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.play) begin
                    w_song_d  = bus.song_sel;
                    w_addr_d  = w_sel_start;
                    w_cnt_d   = 32'd0;
                    w_per_d   = w_per_tempo;
                    w_gap_d   = w_gap_tempo;
                    w_nv_d    = 1'b0;
                    w_state_d = StFetch;
                end
            end
            StFetch: begin
                w_note_d = bus.rom_data;
                w_cnt_d  = 32'd1;
                if (bus.stop) begin
                    w_state_d = StIdle;
                    w_note_d  = 5'd0;
                    w_nv_d    = 1'b0;
                    w_cnt_d   = 32'd0;
                end else if (bus.pause) begin
                    w_nv_d    = 1'b0;
                    w_state_d = StPause;
                end else begin
                    w_nv_d    = (bus.rom_data != 5'd0) && (32'd1 < w_gap_start);
                    w_state_d = StPlay;
                end
            end
            StPlay: begin
                if (bus.stop) begin
                    w_state_d = StIdle;
                    w_note_d  = 5'd0;
                    w_nv_d    = 1'b0;
                    w_cnt_d   = 32'd0;
                end else if (w_last) begin
                    w_cnt_d = 32'd0;
                    w_nv_d  = 1'b0;
                    if (w_at_end && !bus.loop_en) begin
                        w_done_d  = 1'b1;
                        w_note_d  = 5'd0;
                        w_state_d = StIdle;
                    end else begin
                        // END compare covers END3 = 511 so the 9-bit increment never wraps.
                        w_addr_d  = w_at_end ? w_start : r_addr + 9'd1;
                        w_beat_d  = 1'b1;
                        w_per_d   = w_per_tempo;
                        w_gap_d   = w_gap_tempo;
                        w_pend_d  = bus.pause;
                        w_state_d = bus.pause ? StPause : StFetch;
                    end
                end else if (bus.pause) begin
                    w_nv_d    = 1'b0;
                    w_state_d = StPause;
                end else begin
                    w_cnt_d = w_cnt_inc;
                    w_nv_d  = (r_note != 5'd0) && (w_cnt_inc < w_gap_start);
                end
            end
            default: begin
                w_note_d = w_note_now;
                if (bus.stop) begin
                    w_state_d = StIdle;
                    w_note_d  = 5'd0;
                    w_nv_d    = 1'b0;
                    w_cnt_d   = 32'd0;
                end else if (bus.play) begin
                    w_nv_d    = (w_note_now != 5'd0) && (r_cnt < w_gap_start);
                    w_state_d = StPlay;
                end
            end
        endcase
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 32'd0;
            r_per   <= 32'd0;
            r_gap   <= 32'd0;
            r_addr  <= 9'd0;
            r_song  <= 2'd0;
            r_note  <= 5'd0;
            r_nv    <= 1'b0;
            r_beat  <= 1'b0;
            r_done  <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_per   <= w_per_d;
            r_gap   <= w_gap_d;
            r_addr  <= w_addr_d;
            r_song  <= w_song_d;
            r_note  <= w_note_d;
            r_nv    <= w_nv_d;
            r_beat  <= w_beat_d;
            r_done  <= w_done_d;
            r_pend  <= w_pend_d;
        end
    end

    assign bus.rom_addr   = r_addr;
    assign bus.note       = r_note;
    assign bus.note_valid = r_nv;
    assign bus.playing    = (r_state == StFetch) || (r_state == StPlay);
    assign bus.paused     = (r_state == StPause);
    assign bus.beat       = r_beat;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Directed bench for music_seq_ctrl with a 10-cycle beat, 2-cycle gap and a 4-note song 0.
module tb_music_seq_ctrl;

    logic in_clk = 1'b0;
    logic rst    = 1'b1;
    music_seq_ctrl_if bus ();

    logic [4:0] rom [512];
    assign bus.rom_data = rom[bus.rom_addr];

    music_seq_ctrl #(
        .TICK_DIV   (10),
        .GAP_CYCLES (2),
        .END0       (3)
    ) dut (
        .in_clk (in_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        int         t;
        logic [8:0] addr;
        logic [4:0] note;
        logic       nv;
        logic       beat;
        logic       done;
        logic       playing;
    } vec_t;

    vec_t vecs[16];
    int   n_checks = 0;
    int   n_errors = 0;
    int   t        = 0;
    int   n_beat   = 0;
    int   n_done   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d got %0d want %0d", name, t, act, exp);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
        t++;
        if (bus.beat) n_beat++;
        if (bus.done) n_done++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        steps(1);
    endtask

    task automatic start(input logic [1:0] song, input logic [1:0] tmp, input logic lp);
        bus.song_sel = song;
        bus.tempo    = tmp;
        bus.loop_en  = lp;
        bus.play     = 1'b1;
        t      = 0;
        n_beat = 0;
        n_done = 0;
        step();
        bus.play = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_addr"}, int'(bus.rom_addr), 0);
        check({tag, "_note"}, int'(bus.note), 0);
        check({tag, "_nv"}, int'(bus.note_valid), 0);
        check({tag, "_playing"}, int'(bus.playing), 0);
        check({tag, "_paused"}, int'(bus.paused), 0);
        check({tag, "_beat"}, int'(bus.beat), 0);
        check({tag, "_done"}, int'(bus.done), 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 5'd1;
        rom[0]   = 5'd5;
        rom[1]   = 5'd0;
        rom[2]   = 5'd7;
        rom[3]   = 5'd9;
        rom[280] = 5'd3;

        // t is edges since the play pulse was presented; song 0 tempo 0 no loop.
        vecs[0]  = '{1,  9'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{2,  9'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{8,  9'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{9,  9'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{11, 9'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{12, 9'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{16, 9'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{21, 9'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{22, 9'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{28, 9'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{29, 9'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{31, 9'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{32, 9'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{39, 9'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{41, 9'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{60, 9'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        bus.play     = 1'b0;
        bus.pause    = 1'b0;
        bus.stop     = 1'b0;
        bus.song_sel = 2'd0;
        bus.tempo    = 2'd0;
        bus.loop_en  = 1'b0;

        steps(2);
        check_idle_zero("reset");
        rst = 1'b0;
        steps(1);

        // Basic song playback from the vector table
        start(2'd0, 2'd0, 1'b0);
        for (int v = 0; v < 16; v++) begin
            while (t < vecs[v].t) step();
            check($sformatf("play_addr_t%0d", vecs[v].t), int'(bus.rom_addr), int'(vecs[v].addr));
            check($sformatf("play_note_t%0d", vecs[v].t), int'(bus.note), int'(vecs[v].note));
            check($sformatf("play_nv_t%0d", vecs[v].t), int'(bus.note_valid), int'(vecs[v].nv));
            check($sformatf("play_beat_t%0d", vecs[v].t), int'(bus.beat), int'(vecs[v].beat));
            check($sformatf("play_done_t%0d", vecs[v].t), int'(bus.done), int'(vecs[v].done));
            check($sformatf("play_playing_t%0d", vecs[v].t), int'(bus.playing),
                  int'(vecs[v].playing));
        end
        check("play_beat_count", n_beat, 3);
        check("play_done_count", n_done, 1);

        // Looping: address 3 wraps to 0 with a beat and no done
        do_reset();
        start(2'd0, 2'd0, 1'b1);
        while (t < 41) step();
        check("loop_addr", int'(bus.rom_addr), 0);
        check("loop_beat", int'(bus.beat), 1);
        check("loop_playing", int'(bus.playing), 1);
        step();
        check("loop_note", int'(bus.note), 5);
        check("loop_nv", int'(bus.note_valid), 1);
        steps(10);
        check("loop_addr2", int'(bus.rom_addr), 1);
        check("loop_done_count", n_done, 0);
        check("loop_beat_count", n_beat, 5);

        // Tempo 1: P=5, G=1
        do_reset();
        start(2'd0, 2'd1, 1'b0);
        while (t < 4) step();
        check("t1_nv_cnt3", int'(bus.note_valid), 1);
        step();
        check("t1_nv_cnt4", int'(bus.note_valid), 0);
        step();
        check("t1_addr1", int'(bus.rom_addr), 1);
        check("t1_beat1", int'(bus.beat), 1);
        steps(5);
        check("t1_addr2", int'(bus.rom_addr), 2);
        check("t1_beat2", int'(bus.beat), 1);

        // Pause at cnt=4 for 20 cycles, then resume
        do_reset();
        start(2'd0, 2'd0, 1'b0);
        while (t < 5) step();
        bus.pause = 1'b1;
        step();
        bus.pause = 1'b0;
        check("pause_paused", int'(bus.paused), 1);
        check("pause_playing", int'(bus.playing), 0);
        check("pause_note", int'(bus.note), 5);
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("pause_hold_nv%0d", i), int'(bus.note_valid), 0);
            check($sformatf("pause_hold_addr%0d", i), int'(bus.rom_addr), 0);
        end
        check("pause_still", int'(bus.paused), 1);
        bus.play = 1'b1;
        step();
        bus.play = 1'b0;
        check("resume_playing", int'(bus.playing), 1);
        check("resume_nv", int'(bus.note_valid), 1);
        steps(5);
        check("resume_addr_before", int'(bus.rom_addr), 0);
        check("resume_beat_before", int'(bus.beat), 0);
        step();
        check("resume_addr_adv", int'(bus.rom_addr), 1);
        check("resume_beat_adv", int'(bus.beat), 1);

        // Stop on the beat boundary (cnt=9), then play song 2
        do_reset();
        start(2'd0, 2'd0, 1'b0);
        while (t < 10) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("stop_playing", int'(bus.playing), 0);
        check("stop_beat", int'(bus.beat), 0);
        check("stop_done", int'(bus.done), 0);
        check("stop_note", int'(bus.note), 0);
        check("stop_addr", int'(bus.rom_addr), 0);
        steps(12);
        check("stop_quiet", n_beat + n_done, 0);
        start(2'd2, 2'd0, 1'b0);
        check("song2_addr", int'(bus.rom_addr), 280);
        step();
        check("song2_note", int'(bus.note), 3);
        check("song2_nv", int'(bus.note_valid), 1);

        // Asynchronous reset mid-play
        do_reset();
        start(2'd0, 2'd0, 1'b0);
        while (t < 15) step();
        #2;
        rst = 1'b1;
        #1;
        check_idle_zero("async_rst");
        #3;
        rst = 1'b0;
        steps(10);
        check("post_rst_playing", int'(bus.playing), 0);
        check("post_rst_addr", int'(bus.rom_addr), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
